// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned QDEPTH = 2;
  localparam int unsigned CNTW   = $clog2(QDEPTH + 1);

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0100_0000;
  localparam logic [XLEN-1:0] INSN_NOP         = 32'h0000_0013;

  // IDLE: nothing in flight; WAIT: response pending; DROP: pending response is stale
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instruction} pairs between fetch and decode.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  fetch_entry_t    push_entry,
  input  logic            pop,
  input  logic            flush,
  output logic [CNTW-1:0] count,
  output fetch_entry_t    head
);

  localparam fetch_entry_t RESET_ENTRY = '{pc: '0, insn: INSN_NOP};

  fetch_entry_t mem [0:QDEPTH-1];
  logic [0:0]   wr_ptr;
  logic [0:0]   rd_ptr;

  // Storage, pointers and occupancy; flush empties the queue without touching storage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem[0] <= RESET_ENTRY;
      mem[1] <= RESET_ENTRY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch.sv
// RV32I fetch stage: PC sequencing, single-outstanding imem requests, redirect flush.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        f_valid,
  input  logic        f_ready,
  output logic [31:0] f_pc,
  output logic [31:0] f_instruction
);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] req_pc;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic            flush;
  logic [CNTW-1:0] count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Request tracking state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request issue (credit rule), response accept/drop, redirect and next PC
  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    req_fire       = 1'b0;
    push           = 1'b0;
    pop            = 1'b0;
    flush          = 1'b0;
    pc_next        = pc;

    imem_req_valid = !reset && (state == ST_IDLE) && (count < CNTW'(QDEPTH)) && !redirect_valid;
    req_fire       = imem_req_valid && imem_req_ready;
    pop            = f_valid && f_ready;
    flush          = redirect_valid;
    push           = imem_rsp_valid && (state == ST_WAIT) && !redirect_valid;

    case (state)
      ST_IDLE: if (req_fire) state_next = ST_WAIT;
      ST_WAIT: begin
        if (imem_rsp_valid)      state_next = ST_IDLE;
        else if (redirect_valid) state_next = ST_DROP;
      end
      ST_DROP: if (imem_rsp_valid) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    if (redirect_valid) begin
      pc_next = word_align(redirect_pc);
    end else if (req_fire) begin
      pc_next = pc + XLEN'(4);
    end
  end

  // PC and the PC of the request currently in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      pc <= pc_next;
      if (req_fire) begin
        req_pc <= pc;
      end
    end
  end

  assign push_entry = '{pc: req_pc, insn: imem_rsp_data};

  fetch_buffer u_buf (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .count      (count),
    .head       (head)
  );

  assign imem_addr     = pc;
  assign f_valid       = (count != '0);
  assign f_pc          = head.pc;
  assign f_instruction = head.insn;

endmodule
